seg7_step_counter: RTL and testbench

Single-digit step counter driving the 7-segment outputs of the project top (`uo_out[6:0]` segments, `uo_out[7]` decimal point).
- Counts steps from either a debounced push-button or an internal prescaled tick, up or down, with wrap-around.
- Registers the digit's segment pattern directly onto the output pins.
- Sits directly upstream of the top-level output mapping; inputs come from `ui_in` bits.

---
 rtl/seg7_pkg.sv | 59 +++++
 rtl/seg7_step_counter_if.sv | 22 ++
 rtl/btn_debounce.sv | 77 +++++++
 rtl/seg7_step_counter.sv | 89 ++++++++
 tb/tb_seg7_step_counter.sv | 146 ++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared constants, debouncer state type and glyph lookup for the step counter.
// Build macro SEG7_HEX_EN widens the count range to 0..F.
package seg7_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;
  localparam logic [6:0] SEG_A = 7'h77;
  localparam logic [6:0] SEG_B = 7'h7C;
  localparam logic [6:0] SEG_C = 7'h39;
  localparam logic [6:0] SEG_D = 7'h5E;
  localparam logic [6:0] SEG_E = 7'h79;
  localparam logic [6:0] SEG_F = 7'h71;

`ifdef SEG7_HEX_EN
  localparam logic [3:0] DIGIT_MAX = 4'd15;
`else
  localparam logic [3:0] DIGIT_MAX = 4'd9;
`endif

  typedef enum logic [1:0] {
    S_LO = 2'd0,
    W_HI = 2'd1,
    S_HI = 2'd2,
    W_LO = 2'd3
  } db_state_e;

  // Hex glyphs stay in the table; the decimal build never reaches 10..15.
  function automatic logic [6:0] seg7_glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0: g = SEG_0;
      4'h1: g = SEG_1;
      4'h2: g = SEG_2;
      4'h3: g = SEG_3;
      4'h4: g = SEG_4;
      4'h5: g = SEG_5;
      4'h6: g = SEG_6;
      4'h7: g = SEG_7;
      4'h8: g = SEG_8;
      4'h9: g = SEG_9;
      4'hA: g = SEG_A;
      4'hB: g = SEG_B;
      4'hC: g = SEG_C;
      4'hD: g = SEG_D;
      4'hE: g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_step_counter_if.sv
// Control inputs and display outputs of the step counter, bundled as one port.
interface seg7_step_counter_if;
  logic       en;
  logic       btn_raw;
  logic       auto_mode;
  logic       up_dn;
  logic       clear;
  logic [6:0] segments;
  logic       dp;
  logic [3:0] digit;
  logic       wrap;

  modport master (
    output en, btn_raw, auto_mode, up_dn, clear,
    input  segments, dp, digit, wrap
  );

  modport slave (
    input  en, btn_raw, auto_mode, up_dn, clear,
    output segments, dp, digit, wrap
  );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus four-state debouncer; rise pulses once per
// accepted press, level follows the debounced button.
module btn_debounce
  import seg7_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic rise
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The transition fires on the cycle the count would reach DEBOUNCE_CYCLES.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q, sync_d;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync;

  assign sync = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], btn_raw};
    state_d = state_q;
    cnt_d   = cnt_q;
    rise    = 1'b0;
    case (state_q)
      S_LO: if (sync) begin
        cnt_d   = CW'(1);
        state_d = W_HI;
      end
      W_HI: begin
        if (!sync) begin
          state_d = S_LO;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = S_HI;
          rise    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HI: if (!sync) begin
        cnt_d   = CW'(1);
        state_d = W_LO;
      end
      W_LO: begin
        if (sync) begin
          state_d = S_HI;
        end else if (cnt_q >= CNT_LAST) begin
          state_d = S_LO;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_LO;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= S_LO;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = (state_q == S_HI) || (state_q == W_LO);

endmodule

// File: rtl/seg7_step_counter.sv
// Single-digit up/down step counter with registered 7-segment drive.
// Steps come from a debounced button or a prescaled tick; SEG7_HEX_EN selects 0..F.
module seg7_step_counter
  import seg7_pkg::*;
#(
  parameter int PRESCALE        = 10_000_000,
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic                clk,
  input  logic                rst,
  seg7_step_counter_if.slave  bus
);

  localparam int            PW       = $clog2(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic          btn_level, btn_rise;
  logic          unused_level;
  logic          tick, step;
  logic [PW-1:0] pre_q, pre_d;
  logic [3:0]    digit_q, digit_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          wrap_q, wrap_d;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.btn_raw),
    .level   (btn_level),
    .rise    (btn_rise)
  );

  assign unused_level = btn_level;

  always_comb begin
    tick    = bus.en && bus.auto_mode && (pre_q == PRE_LAST);
    step    = bus.en && (bus.auto_mode ? tick : btn_rise);
    pre_d   = pre_q;
    digit_d = digit_q;
    dp_d    = dp_q;
    wrap_d  = 1'b0;

    if (!bus.auto_mode)  pre_d = '0;
    else if (bus.en)     pre_d = tick ? '0 : pre_q + PW'(1);

    if (bus.clear) begin
      pre_d   = '0;
      digit_d = 4'd0;
      dp_d    = 1'b0;
    end else if (step) begin
      dp_d = ~dp_q;
      if (bus.up_dn) begin
        wrap_d  = (digit_q == DIGIT_MAX);
        digit_d = wrap_d ? 4'd0 : digit_q + 4'd1;
      end else begin
        wrap_d  = (digit_q == 4'd0);
        digit_d = wrap_d ? DIGIT_MAX : digit_q - 4'd1;
      end
    end

    // Glyph of the next value so segments and digit land on the same edge.
    seg_d = seg7_glyph(digit_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      digit_q <= 4'd0;
      seg_q   <= SEG_0;
      dp_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      pre_q   <= pre_d;
      digit_q <= digit_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      wrap_q  <= wrap_d;
    end
  end

  assign bus.digit    = digit_q;
  assign bus.segments = seg_q;
  assign bus.dp       = dp_q;
  assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_seg7_step_counter.sv
// Directed vector bench for seg7_step_counter with PRESCALE=4, DEBOUNCE_CYCLES=3.
module tb_seg7_step_counter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg7_step_counter_if bus ();

  seg7_step_counter #(
    .PRESCALE        (4),
    .DEBOUNCE_CYCLES (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef SEG7_HEX_EN
  localparam logic [3:0] EXP_MAX     = 4'hF;
  localparam logic [6:0] EXP_MAX_SEG = 7'h71;
`else
  localparam logic [3:0] EXP_MAX     = 4'd9;
  localparam logic [6:0] EXP_MAX_SEG = 7'h6F;
`endif

  typedef struct {
    string      nm;
    logic       en, am, up, clr, btn;
    int         cyc;
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp, wrap;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(string nm, logic en, logic am, logic up, logic clr,
                              logic btn, int cyc, logic [3:0] dig, logic [6:0] seg,
                              logic dp, logic wrap);
    vec_t v;
    v.nm = nm; v.en = en; v.am = am; v.up = up; v.clr = clr; v.btn = btn;
    v.cyc = cyc; v.dig = dig; v.seg = seg; v.dp = dp; v.wrap = wrap;
    tbl.push_back(v);
  endfunction

  task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(string nm, logic [3:0] dig, logic [6:0] seg, logic dp, logic wrap);
    chk({nm, ".digit"},    {4'd0, bus.digit},    {4'd0, dig});
    chk({nm, ".segments"}, {1'b0, bus.segments}, {1'b0, seg});
    chk({nm, ".dp"},       {7'd0, bus.dp},       {7'd0, dp});
    chk({nm, ".wrap"},     {7'd0, bus.wrap},     {7'd0, wrap});
  endtask

  initial begin
    logic [6:0] gl [10];
    gl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Auto up-count: one step every 4 cycles, wrap only on 9->0.
    for (int k = 1; k <= 9; k++)
      add("auto_up", 1, 1, 1, 0, 0, 4, 4'(k), gl[k], k[0], 0);
`ifdef SEG7_HEX_EN
    add("auto_up", 1, 1, 1, 0, 0, 4, 4'hA, 7'h77, 0, 0);
`else
    add("auto_up", 1, 1, 1, 0, 0, 4, 4'd0, 7'h3F, 0, 1);
`endif
    add("clr0",      1, 0, 1, 1, 0, 1,  0, 7'h3F, 0, 0);
    // Bounce: 2 high, 1 low, then held high -> exactly one step.
    add("bounce_a",  1, 0, 1, 0, 1, 2,  0, 7'h3F, 0, 0);
    add("bounce_b",  1, 0, 1, 0, 0, 1,  0, 7'h3F, 0, 0);
    add("bounce_c",  1, 0, 1, 0, 1, 4,  0, 7'h3F, 0, 0);
    add("bounce_d",  1, 0, 1, 0, 1, 1,  1, 7'h06, 1, 0);
    add("bounce_e",  1, 0, 1, 0, 1, 5,  1, 7'h06, 1, 0);
    add("bounce_f",  1, 0, 1, 0, 0, 10, 1, 7'h06, 1, 0);
    // Down presses: 1->0, then 0->MAX with a wrap pulse.
    add("dn1_a",     1, 0, 0, 0, 1, 4,  1, 7'h06, 1, 0);
    add("dn1_b",     1, 0, 0, 0, 1, 1,  0, 7'h3F, 0, 0);
    add("dn1_c",     1, 0, 0, 0, 1, 5,  0, 7'h3F, 0, 0);
    add("dn1_d",     1, 0, 0, 0, 0, 10, 0, 7'h3F, 0, 0);
    add("dn2_a",     1, 0, 0, 0, 1, 4,  0, 7'h3F, 0, 0);
    add("dn2_wrap",  1, 0, 0, 0, 1, 1,  EXP_MAX, EXP_MAX_SEG, 1, 1);
    add("dn2_after", 1, 0, 0, 0, 1, 1,  EXP_MAX, EXP_MAX_SEG, 1, 0);
    add("dn2_hold",  1, 0, 0, 0, 1, 3,  EXP_MAX, EXP_MAX_SEG, 1, 0);
    add("dn2_rel",   1, 0, 0, 0, 0, 10, EXP_MAX, EXP_MAX_SEG, 1, 0);
    // Clear colliding with tick at digit 5, then clear mid-prescale.
    add("clr1",      1, 0, 1, 1, 0, 1,  0, 7'h3F, 0, 0);
    add("run5",      1, 1, 1, 0, 0, 20, 5, 7'h6D, 1, 0);
    add("pre3",      1, 1, 1, 0, 0, 3,  5, 7'h6D, 1, 0);
    add("clr_tick",  1, 1, 1, 1, 0, 1,  0, 7'h3F, 0, 0);
    add("restart_a", 1, 1, 1, 0, 0, 3,  0, 7'h3F, 0, 0);
    add("restart_b", 1, 1, 1, 0, 0, 1,  1, 7'h06, 1, 0);
    add("pre2",      1, 1, 1, 0, 0, 2,  1, 7'h06, 1, 0);
    add("clr_mid",   1, 1, 1, 1, 0, 1,  0, 7'h3F, 0, 0);
    add("restart_c", 1, 1, 1, 0, 0, 3,  0, 7'h3F, 0, 0);
    add("restart_d", 1, 1, 1, 0, 0, 1,  1, 7'h06, 1, 0);
    // en=0 holds the prescaler and drops button steps.
    add("en_pre2",   1, 1, 1, 0, 0, 2,  1, 7'h06, 1, 0);
    add("en0_hold",  0, 1, 1, 0, 0, 8,  1, 7'h06, 1, 0);
    add("en1_pre3",  1, 1, 1, 0, 0, 1,  1, 7'h06, 1, 0);
    add("en1_step",  1, 1, 1, 0, 0, 1,  2, 7'h5B, 0, 0);
    add("en0_btn",   0, 0, 1, 0, 1, 8,  2, 7'h5B, 0, 0);
    add("en1_btn",   1, 0, 1, 0, 1, 4,  2, 7'h5B, 0, 0);
    add("en1_rel",   1, 0, 1, 0, 0, 10, 2, 7'h5B, 0, 0);

    rst = 1'b1;
    bus.en = 1'b0; bus.btn_raw = 1'b0; bus.auto_mode = 1'b0;
    bus.up_dn = 1'b0; bus.clear = 1'b0;
    repeat (2) @(negedge clk);
    chk_out("reset_hold", 0, 7'h3F, 0, 0);
    rst = 1'b0;
    @(negedge clk);
    chk_out("reset_rel", 0, 7'h3F, 0, 0);

    foreach (tbl[i]) begin
      bus.en = tbl[i].en; bus.auto_mode = tbl[i].am; bus.up_dn = tbl[i].up;
      bus.clear = tbl[i].clr; bus.btn_raw = tbl[i].btn;
      repeat (tbl[i].cyc) @(negedge clk);
      chk_out(tbl[i].nm, tbl[i].dig, tbl[i].seg, tbl[i].dp, tbl[i].wrap);
    end

    // Reset mid-debounce: outputs clear at once and the pending press is lost.
    bus.btn_raw = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk_out("rst_async", 0, 7'h3F, 0, 0);
    bus.btn_raw = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk_out("rst_db_lost", 0, 7'h3F, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
